// File: rtl/riscv_fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states,
// the sequential PC increment and the default reset vector.
package riscv_fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_HOLD,
    S_FAULT
  } fetch_state_e;

  localparam int unsigned PC_INCR = 4;
  localparam logic [63:0] DEFAULT_RESET_VECTOR = 64'h0;

endpackage : riscv_fetch_pkg

// File: rtl/fetch_out_reg.sv
// Output register toward decode: holds inst_data/inst_pc/inst_valid.
// Priority is reset > clear > load > hold. Clear only drops valid; the
// stale word is harmless because decode qualifies it with inst_valid.
module fetch_out_reg #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     data_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            valid,
  output logic [31:0]     data,
  output logic [XLEN-1:0] pc
);

  // Capture a fresh instruction, drop it, or hold it stable for decode.
  // NOTE: the data/pc registers are reset as well as valid, so decode never
  // sees X on the bus even though it should ignore it while valid is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
      pc    <= pc_in;
    end
  end

endmodule : fetch_out_reg

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps exactly one imem request
// outstanding and hands each returned word to decode with its PC.
// Optional feature macro: FETCH_MISALIGN_CHK_EN -- when defined, a redirect
// to a non-word-aligned target latches misalign_fault and parks the unit in
// FAULT until reset; when undefined, the target's low two bits are dropped.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic            misalign_fault
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(3));

  fetch_state_e    state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_pc;
  logic            req_valid_q;
  logic            redirect_bad;
  logic            accept;
  logic            out_load;
  logic            out_clear;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q;
  assign redirect_pc    = redirect_target;
  assign redirect_bad   = redirect && (redirect_target[1:0] != 2'b00) && (state != S_FAULT);
  assign misalign_fault = fault_q;
`else
  assign redirect_pc    = redirect_target & ALIGN_MASK;
  assign redirect_bad   = 1'b0;
  assign misalign_fault = 1'b0;
`endif

  assign accept         = req_valid_q && imem_req_ready;
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc;

  // Fetch FSM: PC update, state sequencing and the registered request valid.
  // NOTE: all state here uses non-blocking assignments so every branch reads
  // the pre-edge values of pc/state regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= RESET_VECTOR;
      req_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q     <= 1'b0;
`endif
    end else if (redirect_bad) begin
      state       <= S_FAULT;
      req_valid_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      fault_q     <= 1'b1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect) pc <= redirect_pc;
          state       <= S_REQ;
          req_valid_q <= 1'b1;
        end
        S_REQ: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (accept) begin
              state       <= S_DRAIN;
              req_valid_q <= 1'b0;
            end
          end else if (accept) begin
            state       <= S_WAIT;
            req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            pc <= redirect_pc;
            if (imem_rsp_valid) begin
              state       <= S_REQ;
              req_valid_q <= 1'b1;
            end else begin
              state <= S_DRAIN;
            end
          end else if (imem_rsp_valid) begin
            state <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (redirect) pc <= redirect_pc;
          if (imem_rsp_valid) begin
            state       <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect) begin
            pc          <= redirect_pc;
            state       <= S_REQ;
            req_valid_q <= 1'b1;
          end else if (inst_ready) begin
            pc          <= pc + XLEN'(PC_INCR);
            state       <= S_REQ;
            req_valid_q <= 1'b1;
          end
        end
        S_FAULT: begin
          req_valid_q <= 1'b0;
        end
        default: begin
          state       <= S_IDLE;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Output-register controls: load on an accepted response, clear when the
  // held instruction leaves (handshake or redirect) or on a fault.
  // NOTE: both controls get a default first so no latch is inferred.
  always_comb begin
    out_load  = 1'b0;
    out_clear = 1'b0;
    if (state == S_WAIT && imem_rsp_valid && !redirect) out_load = 1'b1;
    if (state == S_HOLD && (redirect || inst_ready))    out_clear = 1'b1;
    if (redirect_bad)                                   out_clear = 1'b1;
  end

  fetch_out_reg #(
    .XLEN (XLEN)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (out_load),
    .clear   (out_clear),
    .data_in (imem_rsp_data),
    .pc_in   (pc),
    .valid   (inst_valid),
    .data    (inst_data),
    .pc      (inst_pc)
  );

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed testbench for pc_fetch_unit with a small instruction-memory
// responder and a delivery monitor. Build with +define+FETCH_MISALIGN_CHK_EN
// to exercise the fault path instead of the target-alignment path.
module tb_pc_fetch_unit;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [31:0]     imem_rsp_data = '0;
  logic            inst_valid;
  logic            inst_ready = 1'b0;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            redirect = 1'b0;
  logic [XLEN-1:0] redirect_target = '0;
  logic            misalign_fault;

  int n_checks = 0;
  int n_pass   = 0;
  int mem_lat  = 0;
  int rsp_cnt  = 0;

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_VECTOR (64'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .misalign_fault  (misalign_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] addr);
    return addr[31:0] ^ 32'hDEAD_0013;
  endfunction

  // Monitor: accepted requests and delivered instructions, pre-edge values.
  logic            acc_q = 1'b0;
  logic [XLEN-1:0] acc_addr_q = '0;
  int              acc_cnt = 0;
  int              dlv_cnt = 0;
  logic [XLEN-1:0] dlv_pc = '0;
  always @(posedge clk) begin
    acc_q <= imem_req_valid && imem_req_ready && !reset;
    if (imem_req_valid && imem_req_ready) begin
      acc_cnt    <= acc_cnt + 1;
      acc_addr_q <= imem_req_addr;
    end
    if (inst_valid && inst_ready) begin
      dlv_cnt <= dlv_cnt + 1;
      dlv_pc  <= inst_pc;
    end
  end

  // Memory responder: one-cycle response pulse mem_lat cycles into WAIT.
  logic [XLEN-1:0] rsp_addr = '0;
  initial begin
    forever begin
      @(posedge clk); #1;
      imem_rsp_valid = 1'b0;
      if (reset) begin
        rsp_cnt = 0;
      end else begin
        if (rsp_cnt > 0) begin
          rsp_cnt = rsp_cnt - 1;
          if (rsp_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(rsp_addr);
          end
        end
        if (acc_q) begin
          rsp_addr = acc_addr_q;
          if (mem_lat == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(acc_addr_q);
          end else begin
            rsp_cnt = mem_lat;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; redirect = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b1; mem_lat = 0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int i;
    for (i = 0; i < 10 && !imem_req_valid; i++) step();
    n_checks++;
    if (!imem_req_valid) $display("FAIL %s_req_timeout: no request after %0d cycles", name, i);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect = 1'b0; inst_ready = 1'b1; imem_req_ready = 1'b1;
    step(); step();
    n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b expected 0", inst_valid); else n_pass++;
    n_checks++; if (inst_data !== 32'h0) $display("FAIL reset_inst_data: got %h expected 0", inst_data); else n_pass++;
    n_checks++; if (inst_pc !== 64'h0) $display("FAIL reset_inst_pc: got %h expected 0", inst_pc); else n_pass++;
    n_checks++; if (imem_req_addr !== 64'h0) $display("FAIL reset_pc: got %h expected 0", imem_req_addr); else n_pass++;
    n_checks++; if (misalign_fault !== 1'b0) $display("FAIL reset_fault: got %b expected 0", misalign_fault); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_stream();
    logic [XLEN-1:0] a;
    int d0;
    do_reset();
    wait_req("stream");
    d0 = dlv_cnt;
    for (int i = 0; i < 3; i++) begin
      a = 64'(4 * i);
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== a) $display("FAIL stream_req%0d: got v=%b a=%h expected v=1 a=%h", i, imem_req_valid, imem_req_addr, a); else n_pass++;
      step(); step();
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== a || inst_data !== mem_word(a)) $display("FAIL stream_inst%0d: got v=%b pc=%h d=%h expected v=1 pc=%h d=%h", i, inst_valid, inst_pc, inst_data, a, mem_word(a)); else n_pass++;
      step();
    end
    n_checks++; if (dlv_cnt - d0 !== 3) $display("FAIL stream_count: got %0d expected 3", dlv_cnt - d0); else n_pass++;
  endtask

  task automatic test_req_stall();
    int a0;
    do_reset();
    wait_req("req_stall");
    step(); step(); step();
    imem_req_ready = 1'b0;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) $display("FAIL req_stall_addr%0d: got v=%b a=%h expected v=1 a=4", i, imem_req_valid, imem_req_addr); else n_pass++;
      step();
    end
    imem_req_ready = 1'b1;
    step();
    n_checks++; if (acc_cnt - a0 !== 1 || acc_addr_q !== 64'h4) $display("FAIL req_stall_accepts: got n=%0d a=%h expected n=1 a=4", acc_cnt - a0, acc_addr_q); else n_pass++;
    step();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h4) $display("FAIL req_stall_inst: got v=%b pc=%h expected v=1 pc=4", inst_valid, inst_pc); else n_pass++;
  endtask

  task automatic test_hold_stall();
    int a0;
    do_reset();
    inst_ready = 1'b0;
    wait_req("hold_stall");
    step(); step();
    a0 = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h0 || inst_data !== 32'hDEAD_0013 || imem_req_valid !== 1'b0) $display("FAIL hold_stall%0d: got v=%b pc=%h d=%h req=%b expected v=1 pc=0 d=dead0013 req=0", i, inst_valid, inst_pc, inst_data, imem_req_valid); else n_pass++;
      step();
    end
    n_checks++; if (acc_cnt !== a0) $display("FAIL hold_stall_noreq: got %0d extra requests expected 0", acc_cnt - a0); else n_pass++;
    inst_ready = 1'b1;
    step();
    n_checks++; if (dlv_pc !== 64'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) $display("FAIL hold_stall_release: got dpc=%h req=%b a=%h expected dpc=0 req=1 a=4", dlv_pc, imem_req_valid, imem_req_addr); else n_pass++;
  endtask

  task automatic test_redirect_wait();
    int d0;
    do_reset();
    mem_lat = 1;
    wait_req("redir_wait");
    d0 = dlv_cnt;
    step();
    redirect = 1'b1; redirect_target = 64'h100;
    step();
    redirect = 1'b0;
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL redir_wait_drain: got v=%b req=%b expected 0 0", inst_valid, imem_req_valid); else n_pass++;
    step();
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100) $display("FAIL redir_wait_req: got v=%b req=%b a=%h expected v=0 req=1 a=100", inst_valid, imem_req_valid, imem_req_addr); else n_pass++;
    step(); step(); step();
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 64'h100 || inst_data !== mem_word(64'h100)) $display("FAIL redir_wait_inst: got v=%b pc=%h d=%h expected v=1 pc=100 d=%h", inst_valid, inst_pc, inst_data, mem_word(64'h100)); else n_pass++;
    n_checks++; if (dlv_cnt !== d0) $display("FAIL redir_wait_dropped: got %0d deliveries expected 0", dlv_cnt - d0); else n_pass++;
    mem_lat = 0;
  endtask

  task automatic test_redirect_hold();
    int d0;
    do_reset();
    inst_ready = 1'b0;
    wait_req("redir_hold");
    step(); step();
    d0 = dlv_cnt;
    redirect = 1'b1; redirect_target = 64'h200; inst_ready = 1'b1;
    step();
    redirect = 1'b0;
    n_checks++; if (dlv_cnt - d0 !== 1 || dlv_pc !== 64'h0) $display("FAIL redir_hold_deliver: got n=%0d pc=%h expected n=1 pc=0", dlv_cnt - d0, dlv_pc); else n_pass++;
    n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h200) $display("FAIL redir_hold_req: got v=%b req=%b a=%h expected v=0 req=1 a=200", inst_valid, imem_req_valid, imem_req_addr); else n_pass++;
    step(); step();
    n_checks++; if (inst_pc !== 64'h200 || dlv_cnt - d0 !== 1) $display("FAIL redir_hold_next: got pc=%h n=%0d expected pc=200 n=1", inst_pc, dlv_cnt - d0); else n_pass++;
    step();
    // Wrap: redirect in REQ without acceptance keeps REQ with the new address.
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_req: got req=%b a=%h expected req=1 a=fffffffffffffffc", imem_req_valid, imem_req_addr); else n_pass++;
    step(); step(); step();
    n_checks++; if (dlv_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req_addr !== 64'h0 || imem_req_valid !== 1'b1) $display("FAIL wrap_next: got dpc=%h req=%b a=%h expected dpc=fffffffffffffffc req=1 a=0", dlv_pc, imem_req_valid, imem_req_addr); else n_pass++;
  endtask

`ifdef FETCH_MISALIGN_CHK_EN
  task automatic test_misalign();
    int a0;
    do_reset();
    wait_req("misalign");
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 64'h102;
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    n_checks++; if (misalign_fault !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) $display("FAIL misalign_fault: got f=%b req=%b v=%b expected f=1 req=0 v=0", misalign_fault, imem_req_valid, inst_valid); else n_pass++;
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (imem_req_valid !== 1'b0 || misalign_fault !== 1'b1) $display("FAIL misalign_stuck%0d: got req=%b f=%b expected req=0 f=1", i, imem_req_valid, misalign_fault); else n_pass++;
    end
    n_checks++; if (acc_cnt !== a0) $display("FAIL misalign_noreq: got %0d requests expected 0", acc_cnt - a0); else n_pass++;
    do_reset();
    n_checks++; if (misalign_fault !== 1'b0) $display("FAIL misalign_clear: got %b expected 0", misalign_fault); else n_pass++;
    wait_req("misalign_after");
    n_checks++; if (imem_req_addr !== 64'h0) $display("FAIL misalign_restart: got %h expected 0", imem_req_addr); else n_pass++;
  endtask
`else
  task automatic test_align_force();
    do_reset();
    wait_req("align");
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 64'h102;
    step();
    redirect = 1'b0; imem_req_ready = 1'b1;
    n_checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h100 || misalign_fault !== 1'b0) $display("FAIL align_force: got req=%b a=%h f=%b expected req=1 a=100 f=0", imem_req_valid, imem_req_addr, misalign_fault); else n_pass++;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_stream();
    test_req_stall();
    test_hold_stall();
    test_redirect_wait();
    test_redirect_hold();
`ifdef FETCH_MISALIGN_CHK_EN
    test_misalign();
`else
    test_align_force();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_pc_fetch_unit
